flt_cmp_arbiter: RTL and testbench



---
 rtl/flt_cmp_arbiter_pkg.sv | 44 ++++
 rtl/flt_cmp_arbiter_lt.sv | 47 ++++
 rtl/flt_cmp_arbiter.sv | 131 +++++++++++++
 tb/tb_flt_cmp_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/flt_cmp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// flt_cmp_arbiter_pkg
// Shared definitions for the round-robin floating-point compare arbiter:
// requester count, operand width, FSM state encoding and the round-robin
// search helper used by the arbiter.
// -----------------------------------------------------------------------------
package flt_cmp_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } grant_t;

  // Returns the first set bit of valid searching ptr, ptr+1, ... (mod 4).
  // Candidates are visited farthest-first so the nearest one overwrites the
  // result. The modulo comes for free from the IDX_W-bit add because
  // NUM_REQ is a power of two.
  function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                     input logic [IDX_W-1:0]   ptr);
    grant_t           g;
    logic [IDX_W-1:0] cand;
    g    = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (valid[cand]) begin
        g.hit = 1'b1;
        g.idx = cand;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/flt_cmp_arbiter_lt.sv
// -----------------------------------------------------------------------------
// BBFLessThan
// Combinational IEEE-754 double-precision "less than" comparator.
//   in1, in2 : operands (DATA_W bits)
//   out      : 1 iff in1 < in2; 0 if either operand is NaN; +0 and -0 compare
//              equal.
// -----------------------------------------------------------------------------
module BBFLessThan
  import flt_cmp_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic              out
);

  logic              sign_a;
  logic              sign_b;
  logic [DATA_W-2:0] mag_a;
  logic [DATA_W-2:0] mag_b;
  logic              nan_a;
  logic              nan_b;
  logic              both_zero;

  assign sign_a    = in1[DATA_W-1];
  assign sign_b    = in2[DATA_W-1];
  assign mag_a     = in1[DATA_W-2:0];
  assign mag_b     = in2[DATA_W-2:0];
  assign nan_a     = (&in1[62:52]) && (|in1[51:0]);
  assign nan_b     = (&in2[62:52]) && (|in2[51:0]);
  assign both_zero = (mag_a == '0) && (mag_b == '0);

  // Sign-magnitude ordering: with equal signs the magnitude comparison is
  // direct for positives and reversed for negatives.
  always_comb begin
    out = 1'b0;
    if (nan_a || nan_b || both_zero) begin
      out = 1'b0;
    end else if (sign_a != sign_b) begin
      out = sign_a;
    end else if (!sign_a) begin
      out = (mag_a < mag_b);
    end else begin
      out = (mag_a > mag_b);
    end
  end

endmodule

// File: rtl/flt_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// flt_cmp_arbiter
// Shares one double-precision less-than comparator among NUM_REQ requesters.
// Round-robin grant in IDLE, operands captured on the grant, comparator
// result registered in CMP, one-cycle response strobe in RESP.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   io_req_valid/ready  : per-requester handshake (ready is one-hot or zero)
//   io_req_a/io_req_b   : packed operands, requester i on [64i+63:64i]
//   io_resp_valid       : one-cycle strobe to the owning requester
//   io_resp_lt          : A < B, driven 0 outside RESP
//   io_busy             : FSM not in IDLE
// -----------------------------------------------------------------------------
module flt_cmp_arbiter #(
  parameter int NUM_REQ = flt_cmp_arbiter_pkg::NUM_REQ,
  parameter int DATA_W  = flt_cmp_arbiter_pkg::DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          io_req_valid,
  output logic [NUM_REQ-1:0]          io_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   io_req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   io_req_b,
  output logic [NUM_REQ-1:0]          io_resp_valid,
  output logic                        io_resp_lt,
  output logic                        io_busy
);
  import flt_cmp_arbiter_pkg::*;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  g_q, g_d;
  logic              lt_q, lt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  // Low in the first cycle after reset release so that cycle drives all
  // outputs to zero even if requests are already pending.
  logic              armed_q, armed_d;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  grant_t            grant;
  logic              accept;
  logic              cmp_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = io_req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi] = io_req_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign grant  = rr_pick(io_req_valid, ptr_q);
  assign accept = (state_q == ST_IDLE) && armed_q && grant.hit;

  BBFLessThan BBFLessThan (
    .in1 (a_q),
    .in2 (b_q),
    .out (cmp_out)
  );

  // State register and datapath flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      lt_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      lt_q    <= lt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CMP;
      ST_CMP:  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    ptr_d   = ptr_q;
    g_d     = g_q;
    lt_d    = lt_q;
    a_d     = a_q;
    b_d     = b_q;
    armed_d = 1'b1;
    if (accept) begin
      a_d = a_arr[grant.idx];
      b_d = b_arr[grant.idx];
      g_d = grant.idx;
    end
    if (state_q == ST_CMP) begin
      lt_d = cmp_out;
    end
    if (state_q == ST_RESP) begin
      ptr_d = g_q + IDX_W'(1);
    end
  end

  // Outputs.
  always_comb begin
    io_req_ready  = '0;
    io_resp_valid = '0;
    io_resp_lt    = 1'b0;
    io_busy       = (state_q != ST_IDLE);
    if (accept) begin
      io_req_ready[grant.idx] = 1'b1;
    end
    if (state_q == ST_RESP) begin
      io_resp_valid[g_q] = 1'b1;
      io_resp_lt         = lt_q;
    end
  end

endmodule

// File: tb/tb_flt_cmp_arbiter.sv
module tb_flt_cmp_arbiter;

  localparam logic [63:0] F_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] F_TWO  = 64'h4000000000000000;
  localparam logic [63:0] F_MONE = 64'hBFF0000000000000;
  localparam logic [63:0] F_ZERO = 64'h0000000000000000;
  localparam logic [63:0] F_NZER = 64'h8000000000000000;
  localparam logic [63:0] F_NAN  = 64'h7FF8000000000000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   io_req_valid = '0;
  logic [3:0]   io_req_ready;
  logic [255:0] io_req_a = '0;
  logic [255:0] io_req_b = '0;
  logic [3:0]   io_resp_valid;
  logic         io_resp_lt;
  logic         io_busy;

  flt_cmp_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_a      (io_req_a),
    .io_req_b      (io_req_b),
    .io_resp_valid (io_resp_valid),
    .io_resp_lt    (io_resp_lt),
    .io_busy       (io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [63:0] a;
    logic [63:0] b;
    logic        lt;
    int          due;
  } txn_t;

  txn_t exp_q[$];
  txn_t inflight[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -1;
  bit   check_spacing = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, io_req_ready, 0);
    chk({tag, "_resp_valid"}, io_resp_valid, 0);
    chk({tag, "_resp_lt"}, io_resp_lt, 0);
    chk({tag, "_busy"}, io_busy, 0);
  endtask

  // Raise a request and push its expected result onto the scoreboard.
  // Calls must be made in the order the arbiter is expected to grant them.
  task automatic req(input int i, input logic [63:0] a, input logic [63:0] b, input logic lt);
    txn_t t;
    io_req_a[i*64 +: 64] = a;
    io_req_b[i*64 +: 64] = b;
    io_req_valid[i] = 1'b1;
    t.idx = i; t.a = a; t.b = b; t.lt = lt; t.due = 0;
    exp_q.push_back(t);
  endtask

  // One clock cycle: sample at the falling edge, track accepts and
  // responses, then drop valid for any requester that was accepted.
  task automatic tick();
    logic [3:0] acc;
    txn_t       t;
    @(negedge clock);
    cyc++;
    chk("ready_onehot0", 64'($onehot0(io_req_ready)), 1);
    chk("resp_onehot0", 64'($onehot0(io_resp_valid)), 1);
    chk("busy", io_busy, (inflight.size() != 0));
    if (io_busy) chk("ready_while_busy", io_req_ready, 0);
    if (io_resp_valid == 4'b0) chk("lt_outside_resp", io_resp_lt, 0);
    acc = io_req_valid & io_req_ready;
    if (acc != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", acc, 0);
      end else begin
        t = exp_q.pop_front();
        chk("grant", acc, 64'(4'b1 << t.idx));
        if (check_spacing && last_acc >= 0) chk("grant_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        t.due = cyc + 2;
        inflight.push_back(t);
      end
    end
    if (io_resp_valid != 4'b0) begin
      if (inflight.size() == 0) begin
        chk("spurious_resp", io_resp_valid, 0);
      end else begin
        t = inflight.pop_front();
        chk("resp_valid", io_resp_valid, 64'(4'b1 << t.idx));
        chk("resp_lt", io_resp_lt, t.lt);
        chk("resp_latency", cyc, t.due);
        $display("txn req=%0d a=%h b=%h lt=%0b cyc=%0d", t.idx, t.a, t.b, io_resp_lt, cyc);
      end
    end else if (inflight.size() != 0 && cyc >= inflight[0].due) begin
      chk("resp_missing", cyc, inflight[0].due - 1);
      void'(inflight.pop_front());
    end
    @(posedge clock);
    #1;
    io_req_valid = io_req_valid & ~acc;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || inflight.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || inflight.size() != 0) begin
      chk("drain_timeout", exp_q.size() + inflight.size(), 0);
      exp_q.delete();
      inflight.delete();
    end
  endtask

  initial begin
    txn_t t;

    // Reset with all four requesters already pending.
    reset = 1'b1;
    req(0, F_ONE,  F_TWO,  1'b1);
    req(1, F_ONE,  F_ONE,  1'b0);
    req(2, F_TWO,  F_ONE,  1'b0);
    req(3, F_MONE, F_ZERO, 1'b1);
    tick();
    chk_zero("in_reset");
    tick();
    reset = 1'b0;
    #1;
    chk_zero("first_idle");

    // Grants 0,1,2,3 at three-cycle spacing.
    check_spacing = 1'b1;
    last_acc = -1;
    drain(40);

    // Pointer wrapped to 0 after serving 3: req 0 before req 2.
    last_acc = -1;
    req(0, F_NAN,  F_ONE,  1'b0);
    req(2, F_NZER, F_ZERO, 1'b0);
    drain(20);

    // Pointer now 3: order 3, 0, 1.
    last_acc = -1;
    req(3, F_ZERO, F_ONE,  1'b1);
    req(0, F_MONE, F_TWO,  1'b1);
    req(1, F_ONE,  F_NAN,  1'b0);
    drain(30);

    // Request raised during CMP waits for the next IDLE cycle.
    last_acc = -1;
    req(1, F_TWO, F_MONE, 1'b0);
    tick();
    req(2, F_ONE, F_TWO, 1'b1);
    drain(20);

    // Reset in the CMP cycle discards the in-flight request.
    check_spacing = 1'b0;
    req(1, F_ONE, F_TWO, 1'b1);
    tick();
    chk("midop_accepted", inflight.size(), 1);
    reset = 1'b1;
    io_req_valid[1] = 1'b1;
    if (inflight.size() != 0) begin
      t = inflight.pop_front();
      exp_q.push_front(t);
    end
    #1;
    chk_zero("midop_reset");
    tick();
    tick();
    chk_zero("midop_reset_hold");
    reset = 1'b0;
    #1;
    chk_zero("midop_first_idle");
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
